// File: rtl/cv32e40x_div_iter.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Operands are normalised using the ALU's CLZ and shifter ports, so the
// iteration count scales with the magnitude difference of the operands.
module cv32e40x_div_iter #(
  parameter bit EARLY_OUT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        alu_clz_en_o,
  output logic [31:0] alu_clz_data_o,
  input  logic [5:0]  alu_clz_result_i,
  output logic        alu_shift_en_o,
  output logic [5:0]  alu_shift_amt_o,
  output logic [31:0] alu_shift_op_o,
  input  logic [31:0] alu_shifted_i
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {IDLE, CLZ_A, CLZ_B, SHIFT, COMPUTE, FINISH} state_t;

  state_t state, state_nxt;

  logic              is_signed, is_rem, sign_a, sign_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [5:0]        clz_a, clz_b;
  logic [DATA_W-1:0] d_q, r_q, q_q, result_q;
  logic [4:0]        cnt;

  logic              b_zero, early_out, ge;
  logic [4:0]        amt;
  logic [DATA_W-1:0] r_step, q_step;

  // Two's-complement magnitude; 0x80000000 maps onto itself as an unsigned value.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn);
    return (sgn && (v < 0)) ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Apply the operand signs to the unsigned quotient/remainder and pick the output.
  function automatic logic [DATA_W-1:0] fix_result(input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] r,
                                                   input logic sgnd, input logic rem,
                                                   input logic sa, input logic sb,
                                                   input logic bz);
    logic neg_q, neg_r;
    neg_q = sgnd & (sa ^ sb) & ~bz;
    neg_r = sgnd & sa;
    if (rem) return neg_r ? (DATA_W'(0) - r) : r;
    else     return neg_q ? (DATA_W'(0) - q) : q;
  endfunction

  assign b_zero    = (abs_b == '0);
  assign early_out = EARLY_OUT_EN && (alu_clz_result_i < clz_a);
  // A divisor wider than the dividend only reaches SHIFT with early-out disabled; no shift is needed then.
  assign amt       = (clz_b > clz_a) ? 5'(clz_b - clz_a) : 5'd0;
  assign ge        = (r_q >= d_q);
  assign r_step    = ge ? (r_q - d_q) : r_q;
  assign q_step    = {q_q[DATA_W-2:0], ge};

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == FINISH);
  assign result_o    = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; kill returns any busy state to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i && !kill_i) state_nxt = CLZ_A;
      CLZ_A:   state_nxt = CLZ_B;
      CLZ_B:   state_nxt = (b_zero || early_out) ? FINISH : SHIFT;
      SHIFT:   state_nxt = COMPUTE;
      COMPUTE: if (cnt == 5'd0) state_nxt = FINISH;
      FINISH:  if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill_i && (state != IDLE)) state_nxt = IDLE;
  end

  // Drive the borrowed ALU ports only in the normalisation states.
  always_comb begin
    alu_clz_en_o    = 1'b0;
    alu_clz_data_o  = '0;
    alu_shift_en_o  = 1'b0;
    alu_shift_amt_o = '0;
    alu_shift_op_o  = '0;
    case (state)
      CLZ_A: begin
        alu_clz_en_o   = 1'b1;
        alu_clz_data_o = abs_a;
      end
      CLZ_B: begin
        alu_clz_en_o   = 1'b1;
        alu_clz_data_o = abs_b;
      end
      SHIFT: begin
        alu_shift_en_o  = 1'b1;
        alu_shift_amt_o = {1'b0, amt};
        alu_shift_op_o  = abs_b;
      end
      default: ;
    endcase
  end

  // Operand capture, normalisation and restoring-division datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_signed <= 1'b0;
      is_rem    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      abs_a     <= '0;
      abs_b     <= '0;
      clz_a     <= '0;
      clz_b     <= '0;
      d_q       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      cnt       <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i && !kill_i) begin
          is_signed <= ~operator_i[0];
          is_rem    <= operator_i[1];
          sign_a    <= ~operator_i[0] & op_a_i[31];
          sign_b    <= ~operator_i[0] & op_b_i[31];
          abs_a     <= magnitude(op_a_i, ~operator_i[0]);
          abs_b     <= magnitude(op_b_i, ~operator_i[0]);
        end
        CLZ_A: clz_a <= alu_clz_result_i;
        CLZ_B: begin
          clz_b <= alu_clz_result_i;
          if (!kill_i) begin
            if (b_zero)
              result_q <= fix_result('1, abs_a, is_signed, is_rem, sign_a, sign_b, 1'b1);
            else if (early_out)
              result_q <= fix_result('0, abs_a, is_signed, is_rem, sign_a, sign_b, 1'b0);
          end
        end
        SHIFT: begin
          d_q <= alu_shifted_i;
          r_q <= abs_a;
          q_q <= '0;
          cnt <= amt;
        end
        COMPUTE: begin
          r_q <= r_step;
          q_q <= q_step;
          d_q <= d_q >> 1;
          if (cnt == 5'd0) begin
            if (!kill_i)
              result_q <= fix_result(q_step, r_step, is_signed, is_rem, sign_a, sign_b, 1'b0);
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// Directed bench for cv32e40x_div_iter with a behavioural ALU CLZ/shifter model.
module tb_cv32e40x_div_iter;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  operator_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        kill_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        alu_clz_en_o;
  logic [31:0] alu_clz_data_o;
  logic [5:0]  alu_clz_result_i;
  logic        alu_shift_en_o;
  logic [5:0]  alu_shift_amt_o;
  logic [31:0] alu_shift_op_o;
  logic [31:0] alu_shifted_i;

  int total = 0;
  int bad   = 0;
  logic both_seen = 1'b0;

  cv32e40x_div_iter #(.EARLY_OUT_EN(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .operator_i       (operator_i),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .kill_i           (kill_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .result_o         (result_o),
    .alu_clz_en_o     (alu_clz_en_o),
    .alu_clz_data_o   (alu_clz_data_o),
    .alu_clz_result_i (alu_clz_result_i),
    .alu_shift_en_o   (alu_shift_en_o),
    .alu_shift_amt_o  (alu_shift_amt_o),
    .alu_shift_op_o   (alu_shift_op_o),
    .alu_shifted_i    (alu_shifted_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 6'(31 - i);
    end
    return 6'd32;
  endfunction

  // ALU stand-in: combinational CLZ and left shifter
  always_comb begin
    alu_clz_result_i = clz32(alu_clz_data_o);
    alu_shifted_i    = alu_shift_op_o << alu_shift_amt_o;
  end

  always @(negedge clk) begin
    if (alu_clz_en_o && alu_shift_en_o) both_seen = 1'b1;
  end

  // Present one request; returns #1 after the acceptance edge (cycle 1).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  // Bounded wait for out_valid_o; cyc is the cycle index relative to acceptance.
  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (out_valid_o !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Full operation with out_ready_i=1; returns result and cycle of out_valid_o.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    start_op(op, a, b);
    wait_valid(1, cyc);
    res = result_o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=0",
               out_valid_o, in_ready_o, result_o);
    end
    total++;
    if (alu_clz_en_o !== 1'b0 || alu_shift_en_o !== 1'b0 || alu_clz_data_o !== 32'd0 ||
        alu_shift_op_o !== 32'd0 || alu_shift_amt_o !== 6'd0) begin
      bad++;
      $display("FAIL reset_alu got clz_en=%b sh_en=%b clz_d=%h sh_op=%h amt=%0d want all 0",
               alu_clz_en_o, alu_shift_en_o, alu_clz_data_o, alu_shift_op_o, alu_shift_amt_o);
    end
  endtask

  task automatic test_divu_basic();
    int cyc;
    logic [31:0] res;
    start_op(2'b01, 32'd100, 32'd7);
    total++;
    if (alu_clz_en_o !== 1'b1 || alu_clz_data_o !== 32'd100) begin
      bad++;
      $display("FAIL clz_a_port got en=%b data=%h want en=1 data=00000064", alu_clz_en_o, alu_clz_data_o);
    end
    @(posedge clk); #1;
    total++;
    if (alu_clz_en_o !== 1'b1 || alu_clz_data_o !== 32'd7) begin
      bad++;
      $display("FAIL clz_b_port got en=%b data=%h want en=1 data=00000007", alu_clz_en_o, alu_clz_data_o);
    end
    @(posedge clk); #1;
    total++;
    if (alu_shift_en_o !== 1'b1 || alu_shift_amt_o !== 6'd4 || alu_shift_op_o !== 32'd7 ||
        alu_clz_en_o !== 1'b0) begin
      bad++;
      $display("FAIL shift_port got en=%b amt=%0d op=%h clz_en=%b want en=1 amt=4 op=7 clz_en=0",
               alu_shift_en_o, alu_shift_amt_o, alu_shift_op_o, alu_clz_en_o);
    end
    wait_valid(3, cyc);
    total++;
    if (result_o !== 32'd14 || cyc !== 9) begin
      bad++;
      $display("FAIL divu_100_7 got res=%0d cyc=%0d want res=14 cyc=9", result_o, cyc);
    end
    @(posedge clk); #1;
    run_op(2'b11, 32'd100, 32'd7, res, cyc);
    total++;
    if (res !== 32'd2 || cyc !== 9) begin
      bad++;
      $display("FAIL remu_100_7 got res=%0d cyc=%0d want res=2 cyc=9", res, cyc);
    end
  endtask

  task automatic test_signed();
    int cyc;
    logic [31:0] res;
    run_op(2'b00, 32'hFFFFFFF9, 32'd2, res, cyc);
    total++;
    if (res !== 32'hFFFFFFFD) begin
      bad++;
      $display("FAIL div_m7_2 got %h want fffffffd", res);
    end
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, res, cyc);
    total++;
    if (res !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL rem_m7_2 got %h want ffffffff", res);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [31:0] res;
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
    for (int op = 0; op < 4; op++) begin
      run_op(2'(op), 32'h12345678, 32'd0, res, cyc);
      total++;
      if (res !== exp[op] || cyc !== 3) begin
        bad++;
        $display("FAIL div_zero op=%0d got res=%h cyc=%0d want res=%h cyc=3", op, res, cyc, exp[op]);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [31:0] res;
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, res, cyc);
    total++;
    if (res !== 32'h80000000) begin
      bad++;
      $display("FAIL div_overflow got %h want 80000000", res);
    end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, res, cyc);
    total++;
    if (res !== 32'h00000000) begin
      bad++;
      $display("FAIL rem_overflow got %h want 00000000", res);
    end
  endtask

  task automatic test_early_out();
    int cyc;
    logic [31:0] res;
    run_op(2'b01, 32'd3, 32'h10, res, cyc);
    total++;
    if (res !== 32'd0 || cyc !== 3) begin
      bad++;
      $display("FAIL early_divu got res=%h cyc=%0d want res=0 cyc=3", res, cyc);
    end
    run_op(2'b11, 32'd3, 32'h10, res, cyc);
    total++;
    if (res !== 32'd3 || cyc !== 3) begin
      bad++;
      $display("FAIL early_remu got res=%h cyc=%0d want res=3 cyc=3", res, cyc);
    end
  endtask

  task automatic test_kill();
    logic seen;
    // request with kill asserted must not be accepted
    kill_i = 1'b1;
    start_op(2'b01, 32'd100, 32'd7);
    kill_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b1 || alu_clz_en_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle got rdy=%b clz_en=%b want rdy=1 clz_en=0", in_ready_o, alu_clz_en_o);
    end
    start_op(2'b01, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_compute got rdy=%b vld=%b want rdy=1 vld=0", in_ready_o, out_valid_o);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL kill_no_result got valid_seen=%b want 0", seen);
    end
  endtask

  task automatic test_hold();
    int cyc;
    logic stable;
    out_ready_i = 1'b0;
    start_op(2'b01, 32'd100, 32'd7);
    wait_valid(1, cyc);
    stable = 1'b1;
    repeat (5) begin
      if (out_valid_o !== 1'b1 || result_o !== 32'd14 || in_ready_o !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL hold_finish got stable=%b res=%0d want stable=1 res=14", stable, result_o);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_rst_midop();
    start_op(2'b01, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (result_o !== 32'd0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_midop got res=%h rdy=%b vld=%b want res=0 rdy=1 vld=0",
               result_o, in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_alu_excl();
    total++;
    if (both_seen !== 1'b0) begin
      bad++;
      $display("FAIL alu_exclusive got both_seen=%b want 0", both_seen);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    operator_i  = 2'b00;
    op_a_i      = 32'd0;
    op_b_i      = 32'd0;
    kill_i      = 1'b0;
    out_ready_i = 1'b1;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_early_out();
    test_kill();
    test_hold();
    test_rst_midop();
    test_alu_excl();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
